// File: rtl/bus_cycle_unit_if.sv
// Bus cycle unit interface.
// Groups the request side (op/addr/wdata), the external bus (a, dout, din,
// rd, wr, phi, m1, ready) and the status outputs. The "master" modport is the
// cycle unit's own view. The "slave" modport is the environment's view.
interface bus_cycle_unit_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [1:0]    op;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] din;
  logic          ready;
  logic [AW-1:0] a;
  logic [DW-1:0] dout;
  logic          rd;
  logic          wr;
  logic          phi;
  logic          m1;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic [3:0]    tstate;
  logic          m_end;
  logic          err;

  modport master (
    input  op, addr, wdata, din, ready,
    output a, dout, rd, wr, phi, m1, rdata, rdata_valid, tstate, m_end, err
  );

  modport slave (
    output op, addr, wdata, din, ready,
    input  a, dout, rd, wr, phi, m1, rdata, rdata_valid, tstate, m_end, err
  );
endinterface

// File: rtl/bus_cycle_unit.sv
// Bus cycle unit: generates back-to-back M-cycles of T_PER_M clocks.
// The unit latches a request at the end of tstate 0. It strobes rd/phi/m1
// through tstates 1..T_SAMPLE. It captures read data, or presents write data,
// in the last tstate.
// Optional feature macro BUS_WAIT_STATES_EN adds wait states. With the macro
// defined, ready=0 holds the cycle at T_SAMPLE, up to MAX_WAIT clocks. When
// that limit is reached, err pulses.
// Reset is synchronous and active-low.
module bus_cycle_unit #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int T_PER_M  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  bus_cycle_unit_if.master bus
);

  localparam logic [3:0] T_SAMPLE   = 4'(T_PER_M - 2);
  localparam logic [3:0] T_LAST     = 4'(T_PER_M - 1);
  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  // Phases of one M-cycle:
  //   ADDR   = tstate 0
  //   STROBE = tstates 1..T_SAMPLE
  //   WAIT   = stretched T_SAMPLE
  //   END    = last tstate
  typedef enum logic [1:0] {
    PH_ADDR   = 2'd0,
    PH_STROBE = 2'd1,
    PH_WAIT   = 2'd2,
    PH_END    = 2'd3
  } phase_t;

  phase_t        phase_r, phase_s;
  logic [3:0]    tstate_r, tstate_s;
  logic [1:0]    op_r, op_s;
  logic [DW-1:0] wdata_r, wdata_s;
  logic [AW-1:0] a_r, a_s;
  logic [DW-1:0] dout_r, dout_s;
  logic          rd_r, rd_s;
  logic          wr_r, wr_s;
  logic          phi_r, phi_s;
  logic          m1_r, m1_s;
  logic [DW-1:0] rdata_r, rdata_s;
  logic          rdata_valid_r, rdata_valid_s;
  logic          m_end_r, m_end_s;
  logic          err_r, err_s;
  logic          stretch_s;
  logic          timeout_s;

  function automatic logic is_read_op(input logic [1:0] op);
    return (op == OP_FETCH) || (op == 2'b11);
  endfunction

`ifdef BUS_WAIT_STATES_EN
  logic [7:0] wait_cnt_r, wait_cnt_s;
  logic       at_sample_s;

  // Stretch decision at the sample point; give up after MAX_WAIT stretched clocks.
  always_comb begin
    at_sample_s = ((phase_r == PH_STROBE) && (tstate_r == T_SAMPLE)) || (phase_r == PH_WAIT);
    if (at_sample_s && (op_r != OP_IDLE) && !bus.ready) begin
      if (wait_cnt_r >= MAX_WAIT_W) begin
        stretch_s = 1'b0;
        timeout_s = 1'b1;
      end else begin
        stretch_s = 1'b0 | 1'b1;
        timeout_s = 1'b0;
      end
    end else begin
      stretch_s = 1'b0;
      timeout_s = 1'b0;
    end
    if (stretch_s) begin
      wait_cnt_s = wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_s = 8'd0;
    end
  end

  // Wait counter: counts stretched clocks of the current M-cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_r <= 8'd0;
    end else begin
      wait_cnt_r <= wait_cnt_s;
    end
  end
`else
  logic unused_s;
  assign stretch_s = 1'b0;
  assign timeout_s = 1'b0;
  assign unused_s  = bus.ready ^ (^MAX_WAIT_W);
`endif

  // State register: phase, T-state and the request latched at the end of tstate 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_r  <= PH_ADDR;
      tstate_r <= 4'd0;
      op_r     <= OP_IDLE;
      wdata_r  <= {DW{1'b0}};
    end else begin
      phase_r  <= phase_s;
      tstate_r <= tstate_s;
      op_r     <= op_s;
      wdata_r  <= wdata_s;
    end
  end

  // Next-state: step through the tstates, holding at T_SAMPLE while stretched.
  always_comb begin
    phase_s  = phase_r;
    tstate_s = tstate_r;
    case (phase_r)
      PH_ADDR: begin
        phase_s  = PH_STROBE;
        tstate_s = 4'd1;
      end
      PH_STROBE: begin
        if (tstate_r == T_SAMPLE) begin
          if (stretch_s) begin
            phase_s = PH_WAIT;
          end else begin
            phase_s  = PH_END;
            tstate_s = T_LAST;
          end
        end else begin
          tstate_s = tstate_r + 4'd1;
        end
      end
      PH_WAIT: begin
        if (stretch_s) begin
          phase_s = PH_WAIT;
        end else begin
          phase_s  = PH_END;
          tstate_s = T_LAST;
        end
      end
      PH_END: begin
        phase_s  = PH_ADDR;
        tstate_s = 4'd0;
      end
      default: begin
        phase_s  = PH_ADDR;
        tstate_s = 4'd0;
      end
    endcase
  end

  // Output logic: next values of the registered bus outputs for the upcoming phase.
  always_comb begin
    if (phase_r == PH_ADDR) begin
      op_s    = bus.op;
      a_s     = bus.addr;
      wdata_s = bus.wdata;
    end else begin
      op_s    = op_r;
      a_s     = a_r;
      wdata_s = wdata_r;
    end
    phi_s         = (phase_s == PH_STROBE) || (phase_s == PH_WAIT);
    rd_s          = phi_s && is_read_op(op_s);
    m1_s          = phi_s && (op_s == OP_FETCH);
    m_end_s       = (phase_s == PH_END);
    wr_s          = m_end_s && (op_s == OP_WRITE);
    rdata_valid_s = m_end_s && is_read_op(op_s);
    err_s         = m_end_s && timeout_s;
    if (wr_s) begin
      dout_s = wdata_s;
    end else begin
      dout_s = {DW{1'b0}};
    end
    if (rdata_valid_s) begin
      rdata_s = bus.din;
    end else begin
      rdata_s = rdata_r;
    end
  end

  // Output registers: all bus and status outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r           <= {AW{1'b0}};
      dout_r        <= {DW{1'b0}};
      rd_r          <= 1'b0;
      wr_r          <= 1'b0;
      phi_r         <= 1'b0;
      m1_r          <= 1'b0;
      rdata_r       <= {DW{1'b0}};
      rdata_valid_r <= 1'b0;
      m_end_r       <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      a_r           <= a_s;
      dout_r        <= dout_s;
      rd_r          <= rd_s;
      wr_r          <= wr_s;
      phi_r         <= phi_s;
      m1_r          <= m1_s;
      rdata_r       <= rdata_s;
      rdata_valid_r <= rdata_valid_s;
      m_end_r       <= m_end_s;
      err_r         <= err_s;
    end
  end

  assign bus.a           = a_r;
  assign bus.dout        = dout_r;
  assign bus.rd          = rd_r;
  assign bus.wr          = wr_r;
  assign bus.phi         = phi_r;
  assign bus.m1          = m1_r;
  assign bus.rdata       = rdata_r;
  assign bus.rdata_valid = rdata_valid_r;
  assign bus.tstate      = tstate_r;
  assign bus.m_end       = m_end_r;
  assign bus.err         = err_r;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Testbench for bus_cycle_unit.
// Two units share one stimulus:
//   u0 has T_PER_M=4 and MAX_WAIT=4.
//   u1 has T_PER_M=6 and MAX_WAIT=15.
// A tstate-level model predicts every output, and the compare process checks
// both units on each falling edge. Directed scenarios add literal expectations.
module tb_bus_cycle_unit;
`ifdef BUS_WAIT_STATES_EN
  localparam bit WAITS_EN = 1'b1;
`else
  localparam bit WAITS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  din = 8'h00;
  logic        ready = 1'b1;
  bit          cmp_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  bus_cycle_unit_if #(.AW(16), .DW(8)) bus0 ();
  bus_cycle_unit_if #(.AW(16), .DW(8)) bus1 ();

  assign bus0.op = op;
  assign bus0.addr = addr;
  assign bus0.wdata = wdata;
  assign bus0.din = din;
  assign bus0.ready = ready;
  assign bus1.op = op;
  assign bus1.addr = addr;
  assign bus1.wdata = wdata;
  assign bus1.din = din;
  assign bus1.ready = ready;

  bus_cycle_unit #(.AW(16), .DW(8), .T_PER_M(4), .MAX_WAIT(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bus_cycle_unit #(.AW(16), .DW(8), .T_PER_M(6), .MAX_WAIT(15)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          t;
    int          wcnt;
    logic [1:0]  op;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  rdata;
    logic        valid;
    logic        err;
  } model_t;

  model_t mdl0, mdl1;

  function automatic model_t step(input model_t s, input int tpm, input int mw);
    model_t n;
    bit hold;
    n = s;
    n.valid = 1'b0;
    n.err = 1'b0;
    hold = WAITS_EN && (s.op != 2'b00) && !ready;
    if (!rst) begin
      n.t = 0; n.wcnt = 0; n.op = 2'b00; n.a = 16'h0000; n.wd = 8'h00; n.rdata = 8'h00;
    end else if (s.t == 0) begin
      n.op = op; n.a = addr; n.wd = wdata; n.t = 1;
    end else if (s.t == tpm - 2) begin
      if (hold && s.wcnt < mw) begin
        n.wcnt = s.wcnt + 1;
      end else begin
        n.t = tpm - 1;
        n.wcnt = 0;
        n.err = hold;
        if (s.op == 2'b01 || s.op == 2'b11) begin
          n.rdata = din;
          n.valid = 1'b1;
        end
      end
    end else if (s.t == tpm - 1) begin
      n.t = 0;
    end else begin
      n.t = s.t + 1;
    end
    return n;
  endfunction

  // Model advance on every rising edge.
  always @(posedge clk) begin
    mdl0 <= step(mdl0, 4, 4);
    mdl1 <= step(mdl1, 6, 15);
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  dout;
    logic        rd, wr, phi, m1;
    logic [7:0]  rdata;
    logic        valid;
    logic [3:0]  t;
    logic        m_end, err;
  } obs_t;

  function automatic obs_t obs0();
    obs_t o;
    o.a = bus0.a; o.dout = bus0.dout; o.rd = bus0.rd; o.wr = bus0.wr; o.phi = bus0.phi;
    o.m1 = bus0.m1; o.rdata = bus0.rdata; o.valid = bus0.rdata_valid; o.t = bus0.tstate;
    o.m_end = bus0.m_end; o.err = bus0.err;
    return o;
  endfunction

  function automatic obs_t obs1();
    obs_t o;
    o.a = bus1.a; o.dout = bus1.dout; o.rd = bus1.rd; o.wr = bus1.wr; o.phi = bus1.phi;
    o.m1 = bus1.m1; o.rdata = bus1.rdata; o.valid = bus1.rdata_valid; o.t = bus1.tstate;
    o.m_end = bus1.m_end; o.err = bus1.err;
    return o;
  endfunction

  task automatic cmp_unit(input string u, input obs_t o, input model_t m, input int tpm);
    logic phi_e, rd_e, m1_e, end_e, wr_e;
    logic [7:0] dout_e;
    phi_e = (m.t >= 1) && (m.t <= tpm - 2);
    rd_e = phi_e && (m.op == 2'b01 || m.op == 2'b11);
    m1_e = phi_e && (m.op == 2'b01);
    end_e = (m.t == tpm - 1);
    wr_e = end_e && (m.op == 2'b10);
    dout_e = wr_e ? m.wd : 8'h00;
    chk({u, ".tstate"}, 32'(o.t), 32'(m.t));
    chk({u, ".a"}, 32'(o.a), 32'(m.a));
    chk({u, ".phi"}, 32'(o.phi), 32'(phi_e));
    chk({u, ".rd"}, 32'(o.rd), 32'(rd_e));
    chk({u, ".m1"}, 32'(o.m1), 32'(m1_e));
    chk({u, ".wr"}, 32'(o.wr), 32'(wr_e));
    chk({u, ".dout"}, 32'(o.dout), 32'(dout_e));
    chk({u, ".m_end"}, 32'(o.m_end), 32'(end_e));
    chk({u, ".rdata"}, 32'(o.rdata), 32'(m.rdata));
    chk({u, ".rdata_valid"}, 32'(o.valid), 32'(m.valid));
    chk({u, ".err"}, 32'(o.err), 32'(m.err));
    chk({u, ".rd_and_wr"}, 32'(o.rd & o.wr), 32'd0);
  endtask

  // Compare both units against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_unit("u0", obs0(), mdl0, 4);
      cmp_unit("u1", obs1(), mdl1, 6);
    end
  end

  // ---------------- directed scenarios ----------------
  function automatic logic [3:0] tst(input int which);
    return (which == 0) ? bus0.tstate : bus1.tstate;
  endfunction

  task automatic wait_t0(input int which);
    int n;
    n = 0;
    @(negedge clk);
    while (tst(which) !== 4'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_t0_bound", 32'(n < 40), 32'd1);
  endtask

  task automatic step1();
    @(negedge clk);
    din = (bus1.tstate == 4'd4) ? 8'hC3 : 8'h00;
  endtask

  initial begin
    int k, rdc, endc, errc, errv, n;

    // Reset state
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst.tstate", 32'(bus0.tstate), 32'd0);
    chk("rst.a", 32'(bus0.a), 32'd0);
    chk("rst.rd_wr_phi_m1", 32'({bus0.rd, bus0.wr, bus0.phi, bus0.m1}), 32'd0);
    chk("rst.rdata", 32'(bus0.rdata), 32'd0);
    chk("rst.valid_end_err", 32'({bus0.rdata_valid, bus0.m_end, bus0.err}), 32'd0);
    rst = 1'b1;

    // Fetch 0x0100 with din 0x3E; addr/op changes after tstate 0 are ignored
    wait_t0(0);
    op = 2'b01; addr = 16'h0100; din = 8'h3E;
    @(negedge clk);
    op = 2'b00; addr = 16'h1234;
    chk("fetch.t1", 32'(bus0.tstate), 32'd1);
    chk("fetch.t1.rd_m1_phi", 32'({bus0.rd, bus0.m1, bus0.phi}), 32'h7);
    chk("fetch.t1.a", 32'(bus0.a), 32'h0100);
    @(negedge clk);
    chk("fetch.t2.rd_m1_phi", 32'({bus0.rd, bus0.m1, bus0.phi}), 32'h7);
    @(negedge clk);
    chk("fetch.t3.tstate", 32'(bus0.tstate), 32'd3);
    chk("fetch.t3.rdata", 32'(bus0.rdata), 32'h3E);
    chk("fetch.t3.valid_end", 32'({bus0.rdata_valid, bus0.m_end}), 32'h3);
    chk("fetch.t3.rd_m1_phi", 32'({bus0.rd, bus0.m1, bus0.phi}), 32'h0);
    @(negedge clk);
    chk("fetch.t0.a_held", 32'(bus0.a), 32'h0100);
    chk("fetch.t0.valid", 32'(bus0.rdata_valid), 32'd0);

    // Write 0xA5 to 0xFF80; wdata changed after latch must not leak
    wait_t0(0);
    op = 2'b10; addr = 16'hFF80; wdata = 8'hA5;
    @(negedge clk);
    op = 2'b00; addr = 16'h0000; wdata = 8'h5A;
    chk("write.t1.a", 32'(bus0.a), 32'hFF80);
    chk("write.t1.wr_dout", 32'({bus0.wr, bus0.dout}), 32'h0);
    @(negedge clk);
    chk("write.t2.wr_rd", 32'({bus0.wr, bus0.rd}), 32'h0);
    @(negedge clk);
    chk("write.t3.wr", 32'(bus0.wr), 32'd1);
    chk("write.t3.dout", 32'(bus0.dout), 32'hA5);
    chk("write.t3.a", 32'(bus0.a), 32'hFF80);
    chk("write.t3.rd", 32'(bus0.rd), 32'd0);
    @(negedge clk);
    chk("write.t0.wr_dout", 32'({bus0.wr, bus0.dout}), 32'h0);

    // Reset at tstate 2 of a write
    wait_t0(0);
    op = 2'b10; addr = 16'h4000; wdata = 8'h77;
    @(negedge clk);
    op = 2'b00; addr = 16'h0000;
    @(negedge clk);
    chk("rstmid.t2", 32'(bus0.tstate), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.tstate", 32'(bus0.tstate), 32'd0);
    chk("rstmid.strobes", 32'({bus0.rd, bus0.wr, bus0.phi, bus0.m1}), 32'h0);
    chk("rstmid.a_dout", 32'({bus0.a, bus0.dout}), 32'h0);
    chk("rstmid.rdata", 32'(bus0.rdata), 32'h0);
    chk("rstmid.valid_end_err", 32'({bus0.rdata_valid, bus0.m_end, bus0.err}), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.first_edge_t1", 32'(bus0.tstate), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid.no_wr", 32'(bus0.wr), 32'd0);

    // Read with ready low for 3 sample edges
    wait_t0(0);
    op = 2'b11; addr = 16'h0055; din = 8'h99;
    k = 0; rdc = 0; endc = 0; errc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      k++;
      if (bus0.tstate == 4'd0) break;
      rdc += int'(bus0.rd);
      endc += int'(bus0.m_end);
      errc += int'(bus0.err);
      if (k == 1) op = 2'b00;
      if (k == 2) ready = 1'b0;
      if (k == 5) ready = 1'b1;
    end
    ready = 1'b1;
    chk("wait3.len", 32'(k), WAITS_EN ? 32'd7 : 32'd4);
    chk("wait3.rd_clocks", 32'(rdc), WAITS_EN ? 32'd5 : 32'd2);
    chk("wait3.m_end", 32'(endc), 32'd1);
    chk("wait3.err", 32'(errc), 32'd0);
    chk("wait3.rdata", 32'(bus0.rdata), 32'h99);

    // Read with ready stuck low: timeout after MAX_WAIT=4 stretched clocks
    wait_t0(0);
    op = 2'b11; addr = 16'h0066; din = 8'h6B; ready = 1'b0;
    k = 0; errc = 0; errv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      k++;
      if (bus0.tstate == 4'd0) break;
      if (k == 1) op = 2'b00;
      errc += int'(bus0.err);
      if (bus0.err && bus0.rdata_valid && bus0.tstate == 4'd3) errv++;
    end
    chk("tmo.len", 32'(k), WAITS_EN ? 32'd8 : 32'd4);
    chk("tmo.err_pulses", 32'(errc), WAITS_EN ? 32'd1 : 32'd0);
    chk("tmo.err_with_valid", 32'(errv), WAITS_EN ? 32'd1 : 32'd0);
    chk("tmo.rdata", 32'(bus0.rdata), 32'h6B);
    // Idle op with ready still low is never stretched
    k = 0; rdc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      k++;
      if (bus0.tstate == 4'd0) break;
      rdc += int'(bus0.rd);
    end
    chk("idle.len", 32'(k), 32'd4);
    chk("idle.rd", 32'(rdc), 32'd0);
    ready = 1'b1;

    // Six-clock unit reads: din valid only during tstate 4
    op = 2'b11; addr = 16'h2222;
    n = 0;
    while (bus1.tstate !== 4'd0 && n < 60) begin
      step1();
      n++;
    end
    step1();
    n = 0;
    while (bus1.m_end !== 1'b1 && n < 20) begin
      step1();
      n++;
    end
    chk("t6.tstate_at_end", 32'(bus1.tstate), 32'd5);
    chk("t6.valid", 32'(bus1.rdata_valid), 32'd1);
    chk("t6.rdata", 32'(bus1.rdata), 32'hC3);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      step1();
      k++;
      if (bus1.m_end) break;
    end
    chk("t6.cadence", 32'(k), 32'd6);
    chk("t6.rdata2", 32'(bus1.rdata), 32'hC3);

    op = 2'b00;
    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_cycle_unit.md
BUS_CYCLE_UNIT -- requirements
Module: bus_cycle_unit

Interface
REQ-001 SHALL have parameter AW, default 16, address bus width.
REQ-002 SHALL have parameter DW, default 8, data bus width.
REQ-003 SHALL have parameter T_PER_M, default 4, clocks per M-cycle, legal range 4..16; T_SAMPLE SHALL be derived as T_PER_M-2.
REQ-004 SHALL have parameter MAX_WAIT, default 15, wait-state timeout in clocks, legal range 1..255.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-low.
REQ-007 SHALL have port op, input, 2, bus operation: 00 idle, 01 fetch, 10 write, 11 read.
REQ-008 SHALL have port addr, input, AW, request address.
REQ-009 SHALL have port wdata, input, DW, write data.
REQ-010 SHALL have port din, input, DW, external read data.
REQ-011 SHALL have port ready, input, 1, external wait-state request (low = stretch).
REQ-012 SHALL have port a, output, AW, external address.
REQ-013 SHALL have port dout, output, DW, external write data.
REQ-014 SHALL have ports rd, wr, phi, m1, each output, 1: read strobe, write strobe, bus clock phase, opcode-fetch marker.
REQ-015 SHALL have port rdata, output, DW, last captured read data.
REQ-016 SHALL have port rdata_valid, output, 1, capture pulse.
REQ-017 SHALL have port tstate, output, 4, current T-state.
REQ-018 SHALL have port m_end, output, 1, last clock of the M-cycle.
REQ-019 SHALL have port err, output, 1, wait timeout pulse.

Function
REQ-020 SHALL free-run M-cycles back-to-back, with tstate counting 0..T_PER_M-1 and wrapping to 0, except while stretched.
REQ-021 SHALL sample op, addr and wdata only on the clock edge ending tstate 0; changes at any other time SHALL be ignored until the next M-cycle.
REQ-022 SHALL hold a at the latched addr from tstate 1 through the next tstate 0 inclusive.
REQ-023 SHALL drive phi=1 during tstates 1..T_SAMPLE (including stretch) and phi=0 otherwise.
REQ-024 SHALL drive rd=1 for fetch/read during tstates 1..T_SAMPLE (including stretch) and rd=0 otherwise.
REQ-025 SHALL drive m1=1 for fetch only, during tstates 1..T_SAMPLE.
REQ-026 SHALL capture din into rdata on the edge leaving tstate T_SAMPLE for fetch/read, and SHALL pulse rdata_valid for exactly one clock at tstate T_SAMPLE+1.
REQ-027 SHALL, for write, drive wr=1 and dout=wdata for exactly one clock at tstate T_SAMPLE+1; at all other times dout SHALL be 0 and wr SHALL be 0.
REQ-028 SHALL keep the timing cadence for idle op while asserting no rd, wr, m1, or rdata_valid; phi SHALL still toggle.
REQ-029 SHALL drive m_end=1 only at tstate T_PER_M-1, exactly once per M-cycle.
REQ-030 SHALL never assert rd and wr in the same clock.

Reset
REQ-031 SHALL, while rst=0 at a clock edge, set a=0, dout=0, rd=0, wr=0, phi=0, m1=0, rdata=0, rdata_valid=0, tstate=0, m_end=0, err=0, and clear the wait counter.
REQ-032 SHALL abort an in-flight M-cycle when reset is applied mid-cycle: strobes SHALL be low in the clock after the reset edge, and no rdata update or err SHALL occur.
REQ-033 SHALL begin the first post-reset M-cycle at tstate 0 on the first edge with rst=1.

Configuration
REQ-034 SHALL, with macro BUS_WAIT_STATES_EN defined, hold tstate at T_SAMPLE while ready=0 at a non-idle op; rd/phi/m1 SHALL remain asserted and a wait counter SHALL increment per stretched clock.
REQ-035 SHALL, with BUS_WAIT_STATES_EN defined and the wait counter reaching MAX_WAIT, proceed as if ready=1: capture din as normal and pulse err for one clock coincident with tstate T_SAMPLE+1.
REQ-036 SHALL, without BUS_WAIT_STATES_EN, ignore ready, tie err to 0, exclude the wait counter, and keep M-cycle length fixed at T_PER_M.
REQ-037 SHALL, for idle op, never stretch the M-cycle, regardless of macro.

Verification
REQ-038 SHALL cover: fetch at addr 0x0100 with din=0x3E (T_PER_M=4) -> rd, m1 and phi high at tstates 1-2; rdata=0x3E; rdata_valid and m_end high at tstate 3.
REQ-039 SHALL cover: write of 0xA5 to 0xFF80 -> wr=1 and dout=0xA5 only at tstate 3; rd never high; a=0xFF80 at tstates 1-3.
REQ-040 SHALL cover, with BUS_WAIT_STATES_EN: read with ready low for 3 clocks -> M-cycle lasts 7 clocks, rd held 5 clocks, a single m_end, err=0.
REQ-041 SHALL cover, with BUS_WAIT_STATES_EN: MAX_WAIT=4 and ready stuck low -> stretch of 4 clocks, then err pulse together with rdata_valid, rdata=din.
REQ-042 SHALL cover: rst=0 at tstate 2 of a write -> next clock all outputs 0, no wr pulse, tstate=0 after release.
REQ-043 SHALL cover: T_PER_M=6 with read -> 6-clock cadence, capture on the edge leaving tstate 4, rdata_valid at tstate 5.
